unidad_de_busqueda: RTL

Instruction fetch stage of the single-issue datapath. It holds the program counter and fetches one 32-bit word per instruction from instruction memory over a req/ack handshake. It registers the word and presents it, with its PC and the 6-bit `op` field, to the control unit (`Unidad_de_Control`) through a valid/ready handshake. It also accepts PC redirects from branch/jump resolution.

---
 rtl/unidad_de_busqueda_pkg.sv | 36 +++
 rtl/unidad_de_busqueda_registro_pc.sv | 50 +++++
 rtl/unidad_de_busqueda.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/unidad_de_busqueda_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : unidad_de_busqueda_pkg                                          |
// | Purpose  : Definitions shared by the fetch stage and the control unit:     |
// |            FSM state encoding, HALT opcode, PC increment, op extraction.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package unidad_de_busqueda_pkg;

    // State encoding; the enum below is built on these values
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_REQ  = 2'd1;
    localparam logic [1:0] C_ST_HOLD = 2'd2;
    localparam logic [1:0] C_ST_HALT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_REQ  = C_ST_REQ,
        ST_HOLD = C_ST_HOLD,
        ST_HALT = C_ST_HALT
    } fetch_state_t;

    // Opcode that stops fetching when the HALT feature is built in
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Byte distance between consecutive instructions
    localparam int unsigned PC_INC = 4;

    // Major opcode field of a 32-bit instruction word
    function automatic logic [5:0] op_field(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage
`default_nettype wire

// File: rtl/unidad_de_busqueda_registro_pc.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : registro_pc                                                     |
// | Purpose  : Program counter register. Async reset to RESET_PC, load of a    |
// |            redirect target (priority) or increment by PC_INC (wrapping).   |
// |            Also exposes the value the PC takes on the next edge.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module registro_pc #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_pc,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_nxt
);
    import unidad_de_busqueda_pkg::*;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;

    // Next PC: a redirect beats the sequential increment; the add wraps naturally
    always_comb begin
        w_pc_nxt = r_pc;
        if (i_load) begin
            w_pc_nxt = i_load_pc;
        end else if (i_inc) begin
            w_pc_nxt = r_pc + ADDR_W'(PC_INC);
        end
    end

    // PC state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign o_pc     = r_pc;
    assign o_pc_nxt = w_pc_nxt;

endmodule
`default_nettype wire

// File: rtl/unidad_de_busqueda.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : unidad_de_busqueda                                              |
// | Purpose  : Instruction fetch stage. Fetches one word per instruction over  |
// |            a req/ack memory handshake and hands it, with its PC and op,    |
// |            to the control unit over valid/ready. Accepts PC redirects.     |
// | Options  : FETCH_HALT_EN - op 6'b111111 stops fetch until a redirect.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module unidad_de_busqueda #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,   // at least 32 so op exists
    parameter logic [ADDR_W-1:0] RESET_PC = '0    // word aligned
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_inst,
    output logic [5:0]        o_op,
    output logic [ADDR_W-1:0] o_pc_out,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    input  logic              i_redirect_en,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_halted
);
    import unidad_de_busqueda_pkg::*;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              r_kill;
    logic              w_kill_nxt;
    logic              r_mem_req;
    logic              w_mem_req_nxt;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc_out;
    logic              w_capture;
    logic              w_pc_inc;
    logic              w_req_load;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_redirect_pc;

    // Redirect targets are always word aligned
    assign w_redirect_pc = i_redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};

`ifdef FETCH_HALT_EN
    logic w_is_halt_op;
    assign w_is_halt_op = (o_op == OP_HALT);
`endif

    registro_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_registro_pc (
        .clk       (clk),
        .rst       (rst),
        .i_load    (i_redirect_en),
        .i_load_pc (w_redirect_pc),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc),
        .o_pc_nxt  (w_pc_nxt)
    );

    // Next-state logic. In REQ a low r_mem_req marks the one idle cycle that
    // follows a discarded word; the new request starts after it.
    always_comb begin
        w_state_nxt   = r_state;
        w_kill_nxt    = r_kill;
        w_mem_req_nxt = r_mem_req;
        w_capture     = 1'b0;
        w_pc_inc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt   = ST_REQ;
                w_mem_req_nxt = 1'b1;
            end
            ST_REQ: begin
                if (!r_mem_req) begin
                    w_mem_req_nxt = 1'b1;
                end else if (i_mem_ack) begin
                    // A redirect landing with the ack discards the word directly
                    w_mem_req_nxt = 1'b0;
                    w_kill_nxt    = 1'b0;
                    if (!r_kill && !i_redirect_en) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (i_redirect_en) begin
                    w_kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (i_redirect_en) begin
                    // Held word is dropped (or counts as consumed); target wins
                    w_state_nxt   = ST_REQ;
                    w_mem_req_nxt = 1'b1;
                end else if (i_inst_ready) begin
                    w_pc_inc      = 1'b1;
                    w_state_nxt   = ST_REQ;
                    w_mem_req_nxt = 1'b1;
`ifdef FETCH_HALT_EN
                    if (w_is_halt_op) begin
                        w_state_nxt   = ST_HALT;
                        w_mem_req_nxt = 1'b0;
                    end
`endif
                end
            end
`ifdef FETCH_HALT_EN
            ST_HALT: begin
                if (i_redirect_en) begin
                    w_state_nxt   = ST_REQ;
                    w_mem_req_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt   = ST_IDLE;
                w_kill_nxt    = 1'b0;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // FSM, kill flag and request strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_kill    <= 1'b0;
            r_mem_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_kill    <= w_kill_nxt;
            r_mem_req <= w_mem_req_nxt;
        end
    end

    // Request address is captured only when a request starts, so redirects
    // arriving mid-request never disturb the address seen by memory
    assign w_req_load = w_mem_req_nxt & ~r_mem_req;

    // Outstanding request address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_addr <= RESET_PC;
        end else if (w_req_load) begin
            r_req_addr <= w_pc_nxt;
        end
    end

    // Instruction and its address, captured on an accepted ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst   <= '0;
            r_pc_out <= RESET_PC;
        end else if (w_capture) begin
            r_inst   <= i_mem_rdata;
            r_pc_out <= w_pc;
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_req_addr;
    assign o_inst       = r_inst;
    assign o_op         = op_field(r_inst[31:0]);
    assign o_pc_out     = r_pc_out;
    assign o_inst_valid = (r_state == ST_HOLD);

`ifdef FETCH_HALT_EN
    assign o_halted = (r_state == ST_HALT);
`else
    assign o_halted = 1'b0;
`endif

endmodule
`default_nettype wire
